// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, shared TX/RX state encoding and baud divider helper.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction
endpackage

// File: rtl/uart_param_if.sv
// uart_param_if: host-side transmit request and receive FIFO signals of the UART.
interface uart_param_if #(parameter int DATA_BITS = 8);
  logic                 wr_en;
  logic [DATA_BITS-1:0] din;
  logic                 tx_busy;
  logic                 rd_en;
  logic                 rdy;
  logic [DATA_BITS-1:0] dout;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (output wr_en, din, rd_en,
                  input  tx_busy, rdy, dout, parity_err, frame_err, overrun);
  modport slave  (input  wr_en, din, rd_en,
                  output tx_busy, rdy, dout, parity_err, frame_err, overrun);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with extra-MSB pointers; head is combinational
// and reads as zero while empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop, do_push;

  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full FIFO needs for the push
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end

  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with tick generator, TX/RX FSMs
// and a receive FIFO carrying per-word parity/framing flags.
module uart_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int RX_DEPTH   = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  uart_param_if.slave  bus,
  output logic         tx,
  input  logic         rx
);
  localparam int DIV     = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int BIT_CYC = DIV * OVERSAMPLE;
  localparam int DW      = $clog2(DIV + 1);
  localparam int TCW     = $clog2(BIT_CYC);
  localparam int OCW     = $clog2(OVERSAMPLE);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];

  logic [DW-1:0] div_q;
  logic          rx_tick;
  assign rx_tick = div_q == DW'(DIV - 1);

  state_e               tx_st_q, tx_st_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_end;

  // TX times whole bit periods in clocks so START begins right after acceptance
  assign tx_end = tx_cnt_q == TCW'(BIT_CYC - 1);

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_idx_d = tx_idx_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_cnt_d = (tx_st_q == ST_IDLE || tx_end) ? '0 : tx_cnt_q + TCW'(1);
    case (tx_st_q)
      ST_IDLE: if (bus.wr_en) begin
        tx_st_d  = ST_START;
        tx_sh_d  = bus.din;
        tx_par_d = (PARITY == PAR_ODD) ? ~^bus.din : ^bus.din;
      end
      ST_START: if (tx_end) begin
        tx_st_d  = ST_DATA;
        tx_idx_d = '0;
      end
      ST_DATA: if (tx_end) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == 3'(DATA_BITS - 1)) begin
          tx_st_d  = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          tx_idx_d = '0;
        end
      end
      ST_PARITY: if (tx_end) tx_st_d = ST_STOP;
      ST_STOP: if (tx_end) begin
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == 3'(STOP_BITS - 1)) tx_st_d = ST_IDLE;
      end
      default: tx_st_d = ST_IDLE;
    endcase
  end

  assign tx = tx_st_q == ST_START  ? 1'b0 :
              tx_st_q == ST_DATA   ? tx_sh_q[0] :
              tx_st_q == ST_PARITY ? tx_par_q : 1'b1;
  assign bus.tx_busy = tx_st_q != ST_IDLE;

  logic [1:0]           rx_sync_q;
  logic                 rx_s;
  state_e               rx_st_q, rx_st_d;
  logic [OCW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 push_q, push_d;
  logic [DATA_BITS+1:0] push_data_q, push_data_d;
  logic                 rx_mid;

  assign rx_s   = rx_sync_q[1];
  assign rx_mid = rx_tick && rx_cnt_q == OCW'(OVERSAMPLE - 1);

  always_comb begin
    rx_st_d     = rx_st_q;
    rx_idx_d    = rx_idx_q;
    rx_sh_d     = rx_sh_q;
    rx_perr_d   = rx_perr_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    rx_cnt_d    = (rx_tick && rx_st_q != ST_IDLE) ? rx_cnt_q + OCW'(1) : rx_cnt_q;
    case (rx_st_q)
      ST_IDLE: if (!rx_s) begin
        rx_st_d  = ST_START;
        rx_cnt_d = '0;
      end
      ST_START: if (rx_tick && rx_cnt_q == OCW'(OVERSAMPLE/2 - 1)) begin
        rx_cnt_d  = '0;
        rx_idx_d  = '0;
        rx_perr_d = 1'b0;
        rx_st_d   = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_mid) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
        rx_idx_d = rx_idx_q + 3'd1;
        if (rx_idx_q == 3'(DATA_BITS - 1))
          rx_st_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (rx_mid) begin
        rx_cnt_d  = '0;
        rx_perr_d = (PARITY == PAR_ODD) ? ~^{rx_sh_q, rx_s} : ^{rx_sh_q, rx_s};
        rx_st_d   = ST_STOP;
      end
      ST_STOP: if (rx_mid) begin
        push_d      = 1'b1;
        push_data_d = {rx_sh_q, rx_perr_q, ~rx_s};
        rx_st_d     = ST_IDLE;
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  logic                 fifo_full, fifo_empty, ovr_q, ovr_d;
  logic [DATA_BITS+1:0] head;

  assign ovr_d = bus.rd_en ? 1'b0 : (push_q && fifo_full) ? 1'b1 : ovr_q;

  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      div_q       <= '0;
      tx_st_q     <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_sh_q     <= '0;
      tx_par_q    <= 1'b0;
      rx_sync_q   <= 2'b11;
      rx_st_q     <= ST_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_sh_q     <= '0;
      rx_perr_q   <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ovr_q       <= 1'b0;
    end else begin
      div_q       <= rx_tick ? '0 : div_q + DW'(1);
      tx_st_q     <= tx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_sh_q     <= tx_sh_d;
      tx_par_q    <= tx_par_d;
      rx_sync_q   <= {rx_sync_q[0], rx};
      rx_st_q     <= rx_st_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_sh_q     <= rx_sh_d;
      rx_perr_q   <= rx_perr_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      ovr_q       <= ovr_d;
    end

  uart_rx_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_BITS + 2)) u_fifo (
    .clk   (clock),
    .rst_n (rst_n),
    .push  (push_q),
    .wdata (push_data_q),
    .pop   (bus.rd_en),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.rdy        = !fifo_empty;
  assign bus.dout       = head[DATA_BITS+1:2];
  assign bus.parity_err = head[1];
  assign bus.frame_err  = head[0];
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: directed checks of an 8N1 depth-4 UART and a 7E2 UART,
// driving serial frames by hand or looping tx back into rx.
module tb_uart_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_param_if #(.DATA_BITS(8)) b8();
  uart_param_if #(.DATA_BITS(7)) b7();

  logic tx8, rx8, tx7, rx7;
  logic lb8 = 1'b1, rx_drv = 1'b1, flip7 = 1'b0;
  assign rx8 = lb8 ? tx8 : rx_drv;
  assign rx7 = tx7 ^ flip7;

  uart_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(0), .STOP_BITS(1), .RX_DEPTH(4)) u8 (
    .clock(clk), .reset_n(reset_n), .bus(b8.slave), .tx(tx8), .rx(rx8));

  uart_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(7),
               .PARITY(2), .STOP_BITS(2), .RX_DEPTH(4)) u7 (
    .clock(clk), .reset_n(reset_n), .bus(b7.slave), .tx(tx7), .rx(rx7));

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop_hi;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_bit(input logic v, input int n);
    rx_drv = v;
    cyc(n);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_hi);
    rx_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) rx_bit(d[i], 16);
    if (stop_hi) rx_bit(1'b1, 16);
    else         rx_bit(1'b0, 12);
    rx_bit(1'b1, 24);
  endtask

  task automatic wait_rdy8(input string name);
    int n = 0;
    while (!b8.rdy && n < 400) begin cyc(1); n++; end
    chk(name, b8.rdy, 1);
  endtask

  task automatic wait_rdy7(input string name);
    int n = 0;
    while (!b7.rdy && n < 400) begin cyc(1); n++; end
    chk(name, b7.rdy, 1);
  endtask

  task automatic pop8;
    b8.rd_en = 1'b1;
    cyc(1);
    b8.rd_en = 1'b0;
  endtask

  task automatic pop7;
    b7.rd_en = 1'b1;
    cyc(1);
    b7.rd_en = 1'b0;
  endtask

  task automatic send7(input logic [6:0] d, input logic corrupt);
    b7.din = d;
    b7.wr_en = 1'b1;
    cyc(1);
    b7.wr_en = 1'b0;
    for (int k = 1; k <= 177; k++) begin
      if (corrupt && k == 129) flip7 = 1'b1;
      if (k == 145) flip7 = 1'b0;
      if (k == 16)  chk("t2_start_low", tx7, 0);
      if (k == 25)  chk("t2_bit0", tx7, 1);
      if (k == 41)  chk("t2_bit1", tx7, 0);
      if (k == 121) chk("t2_bit6", tx7, 1);
      if (k == 137) chk("t2_parity", tx7, 0);
      if (k == 170) chk("t2_stop2", tx7, 1);
      if (k == 176) chk("t2_busy_last", b7.tx_busy, 1);
      if (k == 177) chk("t2_busy_end", b7.tx_busy, 0);
      cyc(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    b8.wr_en = 1'b0; b8.din = '0; b8.rd_en = 1'b0;
    b7.wr_en = 1'b0; b7.din = '0; b7.rd_en = 1'b0;
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[4] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
    cyc(3);
    chk("rst_tx", tx8, 1);
    chk("rst_busy", b8.tx_busy, 0);
    chk("rst_rdy", b8.rdy, 0);
    chk("rst_dout", b8.dout, 0);
    chk("rst_perr", b8.parity_err, 0);
    chk("rst_ferr", b8.frame_err, 0);
    chk("rst_ovr", b8.overrun, 0);
    chk("rst_tx7", tx7, 1);
    reset_n = 1'b1;
    cyc(4);

    // 8N1 loopback: START lasts 16 cycles, busy for exactly 160 cycles
    b8.din = 8'hA5;
    b8.wr_en = 1'b1;
    cyc(1);
    b8.wr_en = 1'b0;
    chk("t1_tx_low", tx8, 0);
    chk("t1_busy", b8.tx_busy, 1);
    cyc(15);
    chk("t1_start_end", tx8, 0);
    cyc(1);
    chk("t1_bit0", tx8, 1);
    cyc(143);
    chk("t1_busy_last", b8.tx_busy, 1);
    chk("t1_stop", tx8, 1);
    cyc(1);
    chk("t1_busy_end", b8.tx_busy, 0);
    wait_rdy8("t1_rdy");
    chk("t1_dout", b8.dout, 8'hA5);
    chk("t1_perr", b8.parity_err, 0);
    chk("t1_ferr", b8.frame_err, 0);
    pop8();
    chk("t1_empty", b8.rdy, 0);

    // 7E2 loopback, then a frame whose parity bit is flipped on the line
    send7(7'h55, 1'b0);
    wait_rdy7("t2_rdy");
    chk("t2_dout", b7.dout, 7'h55);
    chk("t2_perr", b7.parity_err, 0);
    chk("t2_ferr", b7.frame_err, 0);
    pop7();
    send7(7'h55, 1'b1);
    wait_rdy7("t2c_rdy");
    chk("t2c_dout", b7.dout, 7'h55);
    chk("t2c_perr", b7.parity_err, 1);
    chk("t2c_ferr", b7.frame_err, 0);
    pop7();
    chk("t2c_empty", b7.rdy, 0);

    // hand-driven rx frames from the vector table
    lb8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_rx(tbl[i].data, tbl[i].stop_hi);
      wait_rdy8($sformatf("t3_rdy[%0d]", i));
      chk($sformatf("t3_dout[%0d]", i), b8.dout, tbl[i].exp_d);
      chk($sformatf("t3_ferr[%0d]", i), b8.frame_err, tbl[i].exp_fe);
      chk($sformatf("t3_perr[%0d]", i), b8.parity_err, 0);
      pop8();
      chk($sformatf("t3_empty[%0d]", i), b8.rdy, 0);
    end
    rx_bit(1'b0, 6);
    rx_bit(1'b1, 40);
    chk("t3_glitch", b8.rdy, 0);

    // overrun: fifth frame into a full FIFO is lost
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h11 * (i + 1));
      send_rx(v, 1'b1);
    end
    chk("t4_rdy", b8.rdy, 1);
    chk("t4_ovr_before", b8.overrun, 0);
    send_rx(8'h55, 1'b1);
    chk("t4_ovr", b8.overrun, 1);
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h11 * (i + 1));
      chk($sformatf("t4_pop[%0d]", i), b8.dout, v);
      pop8();
      if (i == 0) chk("t4_ovr_clr", b8.overrun, 0);
    end
    chk("t4_empty", b8.rdy, 0);

    // pop coinciding with a push into a full FIFO
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h61 + i);
      send_rx(v, 1'b1);
    end
    fork
      send_rx(8'h65, 1'b1);
      begin
        int n = 0;
        while (!u8.push_q && n < 400) begin cyc(1); n++; end
        chk("t6_push_seen", u8.push_q, 1);
        pop8();
      end
    join
    chk("t6_ovr", b8.overrun, 0);
    chk("t6_rdy", b8.rdy, 1);
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h62 + i);
      chk($sformatf("t6_pop[%0d]", i), b8.dout, v);
      pop8();
    end
    chk("t6_empty", b8.rdy, 0);

    // reset mid-frame on both TX and the looped-back RX
    lb8 = 1'b1;
    b8.din = 8'hF0;
    b8.wr_en = 1'b1;
    b7.din = 7'h2A;
    b7.wr_en = 1'b1;
    cyc(1);
    b8.wr_en = 1'b0;
    b7.wr_en = 1'b0;
    cyc(87);
    reset_n = 1'b0;
    #1;
    chk("t5_tx", tx8, 1);
    chk("t5_busy", b8.tx_busy, 0);
    chk("t5_tx7", tx7, 1);
    chk("t5_busy7", b7.tx_busy, 0);
    cyc(3);
    reset_n = 1'b1;
    cyc(4);
    chk("t5_rdy", b8.rdy, 0);
    cyc(100);
    chk("t5_no_ghost", b8.rdy, 0);
    chk("t5_no_ghost7", b7.rdy, 0);
    chk("t5_idle_tx", tx8, 1);
    b8.din = 8'h81;
    b8.wr_en = 1'b1;
    cyc(1);
    b8.wr_en = 1'b0;
    chk("t5_new_tx_low", tx8, 0);
    wait_rdy8("t5_new_rdy");
    chk("t5_new_dout", b8.dout, 8'h81);
    chk("t5_new_ferr", b8.frame_err, 0);
    chk("t5_new_perr", b8.parity_err, 0);
    pop8();
    chk("t5_new_empty", b8.rdy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
